// File: rtl/cell_pos_buffer_pkg.sv
// Shared particle record layout: three 32-bit axes packed {z, y, x}, plus the read-pipeline tag.
package cell_pos_buffer_pkg;

    localparam int POS_WIDTH = 32;
    localparam int NUM_AXES  = 3;
    localparam int REC_WIDTH = POS_WIDTH * NUM_AXES;

    typedef logic [POS_WIDTH-1:0] pos_t;

    // Field order here defines the packing: z in the top bits, x in the bottom.
    typedef struct packed {
        pos_t z;
        pos_t y;
        pos_t x;
    } pos_rec_t;

    // One entry per in-flight read: request seen, bank it targeted, index inside the bank count.
    typedef struct packed {
        logic vld;
        logic bank;
        logic hit;
    } rd_tag_t;

    function automatic pos_rec_t pack_pos(input pos_t x, input pos_t y, input pos_t z);
        pos_rec_t r;
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

endpackage

// File: rtl/cell_pos_buffer_if.sv
// Client-side bundle of the particle buffer: read port, append port and bank swap.
interface cell_pos_buffer_if
    import cell_pos_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = REC_WIDTH,
    parameter int ADDR_WIDTH = 8
);

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH:0]   rd_count;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  wr_full;
    logic                  overflow;

    logic                  swap;

    modport master (
        output rd_req, rd_addr, wr_en, wr_data, swap,
        input  rd_valid, rd_data, rd_count, wr_count, wr_full, overflow
    );

    modport slave (
        input  rd_req, rd_addr, wr_en, wr_data, swap,
        output rd_valid, rd_data, rd_count, wr_count, wr_full, overflow
    );

endinterface

// File: rtl/cell_ram_bank.sv
// Single-port RAM bank, address at cycle N and registered data out at N+2; no backpressure.
// Storage and output registers are never reset, so the owner masks rdata with its own valid.
module cell_ram_bank #(
    parameter int WIDTH      = 96,
    parameter int DEPTH      = 220,
    parameter int ADDR_WIDTH = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int MEM_DEPTH = (DEPTH > 0) ? DEPTH : 1;

    logic [WIDTH-1:0] mem [MEM_DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rd_q <= mem[addr];
            end
        end
        rdata <= rd_q;
    end

endmodule

// File: rtl/cell_pos_buffer.sv
// Double-banked particle store: appends fill the write bank while the read bank serves 2-cycle pipelined reads.
// No backpressure; an append to a full bank is dropped and flagged in a sticky overflow bit.
module cell_pos_buffer
    import cell_pos_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = REC_WIDTH,
    parameter int DEPTH      = 220,
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_COUNT = 0,
    parameter     INIT_FILE  = ""
) (
    input  logic             clock,
    input  logic             rst,
    cell_pos_buffer_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] INIT_C  = (ADDR_WIDTH+1)'(INIT_COUNT);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    logic                  bank_sel;
    logic [ADDR_WIDTH:0]   rd_count_q;
    logic [ADDR_WIDTH:0]   wr_count_q;
    logic                  overflow_q;

    logic                  wr_full;
    logic                  wr_accept;
    logic                  rd_hit;

    rd_tag_t               tag_s1;
    rd_tag_t               tag_s2;

    logic [1:0]            ram_en;
    logic [1:0]            ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr  [2];
    logic [DATA_WIDTH-1:0] ram_rdata [2];

    assign wr_full   = (wr_count_q == DEPTH_C);
    assign wr_accept = bus.wr_en && !wr_full;
    assign rd_hit    = bus.rd_req && ({1'b0, bus.rd_addr} < rd_count_q);

    // A same-cycle append still lands in the outgoing bank, so it is folded into the new read count.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bank_sel   <= 1'b0;
            rd_count_q <= INIT_C;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
        end else if (bus.swap) begin
            bank_sel   <= ~bank_sel;
            rd_count_q <= wr_accept ? (wr_count_q + ONE_C) : wr_count_q;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_count_q <= wr_count_q + ONE_C;
            end
            if (bus.wr_en && wr_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Each read carries the bank it was issued against, so a later swap cannot redirect it.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1 <= '{vld: bus.rd_req, bank: bank_sel, hit: rd_hit};
            tag_s2 <= tag_s1;
        end
    end

    always_comb begin
        ram_en               = '0;
        ram_we               = '0;
        ram_addr[0]          = bus.rd_addr;
        ram_addr[1]          = bus.rd_addr;
        ram_en[bank_sel]     = rd_hit;
        ram_en[~bank_sel]    = wr_accept;
        ram_we[~bank_sel]    = wr_accept;
        ram_addr[~bank_sel]  = wr_count_q[ADDR_WIDTH-1:0];
    end

    cell_ram_bank #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_bank0 (
        .clock (clock),
        .en    (ram_en[0]),
        .we    (ram_we[0]),
        .addr  (ram_addr[0]),
        .wdata (bus.wr_data),
        .rdata (ram_rdata[0])
    );

    cell_ram_bank #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  ("")
    ) u_bank1 (
        .clock (clock),
        .en    (ram_en[1]),
        .we    (ram_we[1]),
        .addr  (ram_addr[1]),
        .wdata (bus.wr_data),
        .rdata (ram_rdata[1])
    );

    // Out-of-range reads still produce a valid beat, but with an all-zero record.
    assign bus.rd_valid = tag_s2.vld;
    assign bus.rd_data  = tag_s2.hit ? ram_rdata[tag_s2.bank] : '0;
    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
    assign bus.wr_full  = wr_full;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_cell_pos_buffer.sv
// Directed bench: bank fill/swap/read on an 8-deep instance, full/overflow/reset on a 4-deep one.
module tb_cell_pos_buffer;
    import cell_pos_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [95:0] img     [5];
    logic [95:0] brec    [5];
    logic [95:0] exp_rec [8];

    localparam logic [95:0] REC_A = 96'haaaa0003_aaaa0002_aaaa0001;
    localparam logic [95:0] REC_B = 96'hbbbb0003_bbbb0002_bbbb0001;
    localparam logic [95:0] REC_C = 96'hcccc0003_cccc0002_cccc0001;
    localparam logic [95:0] REC_E = 96'heeee0003_eeee0002_eeee0001;
    localparam logic [95:0] REC_F = 96'hffff0003_ffff0002_ffff0001;
    localparam logic [95:0] REC_G = 96'h12340003_56780002_9abc0001;

    cell_pos_buffer_if #(.DATA_WIDTH(96), .ADDR_WIDTH(3)) ifa ();
    cell_pos_buffer_if #(.DATA_WIDTH(96), .ADDR_WIDTH(2)) ifb ();

    cell_pos_buffer #(
        .DATA_WIDTH(96), .DEPTH(8), .ADDR_WIDTH(3), .INIT_COUNT(5), .INIT_FILE("")
    ) dut_a (
        .clock (clk),
        .rst   (rst_a),
        .bus   (ifa)
    );

    cell_pos_buffer #(
        .DATA_WIDTH(96), .DEPTH(4), .ADDR_WIDTH(2), .INIT_COUNT(0), .INIT_FILE("")
    ) dut_b (
        .clock (clk),
        .rst   (rst_b),
        .bus   (ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic a_write(input logic [95:0] rec);
        ifa.wr_en   = 1'b1;
        ifa.wr_data = rec;
        tick();
        ifa.wr_en   = 1'b0;
    endtask

    task automatic a_swap();
        ifa.swap = 1'b1;
        tick();
        ifa.swap = 1'b0;
    endtask

    task automatic a_read_one(input logic [2:0] addr, input logic [95:0] exp, input string tag);
        ifa.rd_req  = 1'b1;
        ifa.rd_addr = addr;
        tick();
        ifa.rd_req  = 1'b0;
        check({tag, "_n1_vld"}, 128'(ifa.rd_valid), 128'(0));
        tick();
        check({tag, "_n2_vld"}, 128'(ifa.rd_valid), 128'(1));
        check({tag, "_dat"}, 128'(ifa.rd_data), 128'(exp));
    endtask

    // Back-to-back reads of 0..n-1; beat k is expected exactly two cycles after its request.
    task automatic a_read_burst(input int n, input string tag);
        for (int k = 0; k < n + 3; k++) begin
            if (k >= 2 && k < n + 2) begin
                check($sformatf("%s_vld%0d", tag, k), 128'(ifa.rd_valid), 128'(1));
                check($sformatf("%s_dat%0d", tag, k - 2), 128'(ifa.rd_data), 128'(exp_rec[k-2]));
            end else begin
                check($sformatf("%s_vld%0d", tag, k), 128'(ifa.rd_valid), 128'(0));
            end
            ifa.rd_req  = (k < n);
            ifa.rd_addr = 3'(k);
            tick();
        end
        ifa.rd_req = 1'b0;
    endtask

    task automatic b_write(input logic [95:0] rec);
        ifb.wr_en   = 1'b1;
        ifb.wr_data = rec;
        tick();
        ifb.wr_en   = 1'b0;
    endtask

    task automatic b_read_one(input logic [1:0] addr, input logic [95:0] exp, input string tag);
        ifb.rd_req  = 1'b1;
        ifb.rd_addr = addr;
        tick();
        ifb.rd_req  = 1'b0;
        tick();
        check({tag, "_vld"}, 128'(ifb.rd_valid), 128'(1));
        check({tag, "_dat"}, 128'(ifb.rd_data), 128'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1);
    end

    initial begin
        img[0]  = 96'h0000000a_00000014_0000001e;
        img[1]  = 96'h11111111_22222222_33333333;
        img[2]  = 96'hdeadbeef_cafef00d_01234567;
        img[3]  = 96'h80000000_7fffffff_00000001;
        img[4]  = 96'hffffffff_00000000_ffffffff;
        brec[0] = 96'h0b000000_0b000001_0b000002;
        brec[1] = 96'h0b100000_0b100001_0b100002;
        brec[2] = 96'h0b200000_0b200001_0b200002;
        brec[3] = 96'h0b300000_0b300001_0b300002;
        brec[4] = 96'h0b400000_0b400001_0b400002;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.rd_req = 1'b0; ifa.rd_addr = '0; ifa.wr_en = 1'b0; ifa.wr_data = '0; ifa.swap = 1'b0;
        ifb.rd_req = 1'b0; ifb.rd_addr = '0; ifb.wr_en = 1'b0; ifb.wr_data = '0; ifb.swap = 1'b0;
        tick();
        tick();

        check("a_rst_vld",   128'(ifa.rd_valid), 128'(0));
        check("a_rst_dat",   128'(ifa.rd_data),  128'(0));
        check("a_rst_rdcnt", 128'(ifa.rd_count), 128'(5));
        check("a_rst_wrcnt", 128'(ifa.wr_count), 128'(0));
        check("a_rst_full",  128'(ifa.wr_full),  128'(0));
        check("a_rst_ovf",   128'(ifa.overflow), 128'(0));
        check("b_rst_rdcnt", 128'(ifb.rd_count), 128'(0));
        check("b_rst_full",  128'(ifb.wr_full),  128'(0));
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Build an image in bank 0 through the normal path, then reset: storage must survive.
        for (int i = 0; i < 5; i++) a_write(96'h100 + 96'(i));
        a_swap();
        check("a_swap1_rdcnt", 128'(ifa.rd_count), 128'(5));
        check("a_swap1_wrcnt", 128'(ifa.wr_count), 128'(0));
        for (int i = 0; i < 5; i++) a_write(img[i]);
        check("a_img_wrcnt", 128'(ifa.wr_count), 128'(5));
        rst_a = 1'b1;
        tick();
        check("a_rst2_rdcnt", 128'(ifa.rd_count), 128'(5));
        check("a_rst2_wrcnt", 128'(ifa.wr_count), 128'(0));
        rst_a = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) exp_rec[i] = img[i];
        a_read_burst(5, "img");
        a_read_one(3'd5, 96'h0, "oob5");

        // Append A,B,C over stale bank-1 contents, swap, read them back.
        a_write(REC_A);
        a_write(REC_B);
        a_write(REC_C);
        check("abc_wrcnt", 128'(ifa.wr_count), 128'(3));
        a_swap();
        check("abc_rdcnt", 128'(ifa.rd_count), 128'(3));
        check("abc_wrcnt0", 128'(ifa.wr_count), 128'(0));
        exp_rec[0] = REC_A;
        exp_rec[1] = REC_B;
        exp_rec[2] = REC_C;
        a_read_burst(3, "abc");
        a_read_one(3'd3, 96'h0, "oob3");

        // Read at N, swap at N+1: data still from the pre-swap bank.
        ifa.rd_req  = 1'b1;
        ifa.rd_addr = 3'd0;
        tick();
        ifa.rd_req  = 1'b0;
        ifa.swap    = 1'b1;
        tick();
        ifa.swap    = 1'b0;
        check("rs_vld", 128'(ifa.rd_valid), 128'(1));
        check("rs_dat", 128'(ifa.rd_data),  128'(REC_A));
        check("rs_rdcnt", 128'(ifa.rd_count), 128'(0));
        a_read_one(3'd0, 96'h0, "empty");

        // Append and swap in the same cycle with two records already in the write bank.
        a_write(REC_E);
        a_write(REC_F);
        check("ws_wrcnt2", 128'(ifa.wr_count), 128'(2));
        ifa.wr_en   = 1'b1;
        ifa.wr_data = REC_G;
        ifa.swap    = 1'b1;
        tick();
        ifa.wr_en   = 1'b0;
        ifa.swap    = 1'b0;
        check("ws_rdcnt", 128'(ifa.rd_count), 128'(3));
        check("ws_wrcnt", 128'(ifa.wr_count), 128'(0));
        check("ws_ovf",   128'(ifa.overflow), 128'(0));
        a_read_one(3'd2, REC_G, "ws2");
        a_read_one(3'd0, REC_E, "ws0");

        // Depth-4 instance: fill past full.
        for (int i = 0; i < 5; i++) begin
            ifb.wr_en   = 1'b1;
            ifb.wr_data = brec[i];
            tick();
            check($sformatf("full_wrcnt%0d", i), 128'(ifb.wr_count), 128'((i < 4) ? i + 1 : 4));
            check($sformatf("full_flag%0d", i),  128'(ifb.wr_full),  128'(i >= 3));
            check($sformatf("full_ovf%0d", i),   128'(ifb.overflow), 128'(i == 4));
        end
        ifb.wr_en = 1'b0;
        ifb.swap  = 1'b1;
        tick();
        ifb.swap  = 1'b0;
        check("ovf_swap_ovf",   128'(ifb.overflow), 128'(0));
        check("ovf_swap_rdcnt", 128'(ifb.rd_count), 128'(4));
        check("ovf_swap_wrcnt", 128'(ifb.wr_count), 128'(0));
        check("ovf_swap_full",  128'(ifb.wr_full),  128'(0));
        b_read_one(2'd0, brec[0], "drop0");
        b_read_one(2'd3, brec[3], "drop3");

        // Dropped append in the same cycle as a swap leaves overflow clear.
        for (int i = 0; i < 4; i++) b_write(brec[i]);
        ifb.wr_en   = 1'b1;
        ifb.wr_data = brec[4];
        ifb.swap    = 1'b1;
        tick();
        ifb.wr_en   = 1'b0;
        ifb.swap    = 1'b0;
        check("fs_ovf",   128'(ifb.overflow), 128'(0));
        check("fs_rdcnt", 128'(ifb.rd_count), 128'(4));
        check("fs_wrcnt", 128'(ifb.wr_count), 128'(0));

        for (int i = 0; i < 5; i++) b_write(brec[i]);
        check("pre_rst_ovf",  128'(ifb.overflow), 128'(1));
        check("pre_rst_full", 128'(ifb.wr_full),  128'(1));

        // Reset one cycle after a read request: the read must vanish.
        ifb.rd_req  = 1'b1;
        ifb.rd_addr = 2'd0;
        tick();
        ifb.rd_req  = 1'b0;
        rst_b       = 1'b1;
        tick();
        check("mr_vld",   128'(ifb.rd_valid), 128'(0));
        check("mr_dat",   128'(ifb.rd_data),  128'(0));
        check("mr_rdcnt", 128'(ifb.rd_count), 128'(0));
        check("mr_wrcnt", 128'(ifb.wr_count), 128'(0));
        check("mr_full",  128'(ifb.wr_full),  128'(0));
        check("mr_ovf",   128'(ifb.overflow), 128'(0));
        tick();
        check("mr_vld2", 128'(ifb.rd_valid), 128'(0));
        rst_b = 1'b0;
        tick();
        check("mr_vld3", 128'(ifb.rd_valid), 128'(0));
        tick();
        check("mr_vld4", 128'(ifb.rd_valid), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cell_pos_buffer.md
CELL_POS_BUFFER -- requirements
Module: cell_pos_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning one particle record {posz, posy, posx}, 32 bits each.
REQ-002 SHALL have parameter DEPTH, default 220, meaning the maximum number of particles per bank.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, meaning the particle index width; DEPTH SHALL be at most 2^ADDR_WIDTH.
REQ-004 SHALL have parameter INIT_COUNT, default 0, meaning the particle count loaded into bank 0 at reset.
REQ-005 SHALL have parameter INIT_FILE, default "", meaning the preload image for bank 0.
REQ-006 SHALL have port clock, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port rd_req, input, 1: read request on the read bank.
REQ-009 SHALL have port rd_addr, input, ADDR_WIDTH: particle index to read.
REQ-010 SHALL have port rd_valid, output, 1: rd_data is valid this cycle.
REQ-011 SHALL have port rd_data, output, DATA_WIDTH: particle record.
REQ-012 SHALL have port rd_count, output, ADDR_WIDTH+1: particle count of the read bank.
REQ-013 SHALL have port wr_en, input, 1: append wr_data to the write bank.
REQ-014 SHALL have port wr_data, input, DATA_WIDTH: record to append.
REQ-015 SHALL have port wr_count, output, ADDR_WIDTH+1: particle count of the write bank.
REQ-016 SHALL have port wr_full, output, 1: wr_count equals DEPTH.
REQ-017 SHALL have port overflow, output, 1: sticky flag, an append was dropped.
REQ-018 SHALL have port swap, input, 1: exchange the read and write banks.

Function
REQ-019 SHALL hold two banks of DEPTH x DATA_WIDTH; the internal bit bank_sel picks the read bank, and the other bank is the write bank.
REQ-020 Read latency SHALL be exactly 2 cycles: rd_req at cycle N gives rd_valid=1 with rd_data at N+2; reads SHALL be fully pipelined, one per cycle.
REQ-021 rd_addr >= rd_count SHALL still return rd_valid=1 at N+2, with rd_data all zeros.
REQ-022 Each read SHALL carry bank_sel as sampled at cycle N, so a swap at N+1 does not change the data returned.
REQ-023 wr_en with wr_full=0 SHALL write wr_data at address wr_count and increment wr_count the next cycle.
REQ-024 wr_en with wr_full=1 SHALL not write memory, SHALL leave wr_count unchanged, and SHALL set overflow.
REQ-025 A swap pulse SHALL invert bank_sel next cycle, load rd_count from the old wr_count, clear the new wr_count to 0, and clear overflow.
REQ-026 For swap and wr_en in the same cycle, the append SHALL land in the outgoing write bank and SHALL be counted in the new rd_count; overflow from that same append SHALL remain cleared.
REQ-027 Reads and appends SHALL address different banks, so there is no read-during-write hazard.
REQ-028 Counters SHALL never exceed DEPTH and SHALL never wrap.

Reset
REQ-029 While rst=1: bank_sel=0, rd_count=INIT_COUNT, wr_count=0, wr_full=0 (1 if DEPTH=0), overflow=0, rd_valid=0, read pipeline flushed, rd_data=0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset mid-read SHALL drop in-flight reads, and no rd_valid SHALL follow.

Structure
REQ-032 The record field widths (POS_WIDTH=32, three axes) and the packing order {z,y,x} SHALL come from the shared define/package file.
REQ-033 SHALL instantiate the sub-module cell_ram_bank twice; cell_ram_bank is a single-port registered-output RAM with 2-cycle latency, parametrised by width, depth and init file.
REQ-034 Counters, bank select, the valid/bank-tag pipeline and the zero mask SHALL be in cell_pos_buffer.

Verification
REQ-035 Reset with INIT_COUNT=5 and preloaded bank 0; read addresses 0..4 back-to-back -> five rd_valid pulses on consecutive cycles starting 2 cycles after the first request, data matching the image.
REQ-036 Append 3 records A,B,C, swap, read 0..2 -> A,B,C, with rd_count=3 and wr_count=0.
REQ-037 With DEPTH=4, append 5 records -> wr_full=1 after the 4th, 5th dropped, overflow=1, wr_count=4; a following swap clears overflow.
REQ-038 Read addr 0 at N, swap at N+1 -> data at N+2 comes from the pre-swap bank.
REQ-039 wr_en and swap in the same cycle with wr_count=2 -> rd_count=3 next cycle and the record readable at index 2.
REQ-040 Assert rst one cycle after rd_req -> no rd_valid, all outputs at their reset values.
